// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction width, reset/bubble defaults and
// the fetch-stage state encoding.
package pipeline_pkg;

  localparam int INSTR_W = 32;

  localparam logic [31:0]        RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // FETCH: a request is outstanding. HOLD: word captured, decode is stalled.
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / hold / bubble controls.
// Load has priority over bubble; neither asserted means hold.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               bubble,
  input  logic [31:0]        next_pc_4,
  input  logic [INSTR_W-1:0] next_instruction,
  output logic [31:0]        pc_4,
  output logic [INSTR_W-1:0] instruction,
  output logic               valid
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_4        <= '0;
      instruction <= NOP_INSTR;
      valid       <= 1'b0;
    end else if (load) begin
      pc_4        <= next_pc_4;
      instruction <= next_instruction;
      valid       <= 1'b1;
    end else if (bubble) begin
      // pc_4 is left alone: a bubble only invalidates the instruction slot.
      instruction <= NOP_INSTR;
      valid       <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem request/ready handshake and the
// IF/ID register, with stall handling and single-delay-slot redirects.
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0]        RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shouldStall,
  input  logic               shouldJumpOrBranch,
  input  logic [31:0]        jumpOrBranchPc,
  output logic [31:0]        imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [31:0]        pc_4,
  output logic [INSTR_W-1:0] instruction,
  output logic               idValid
`ifdef DEBUG
  ,
  output logic [31:0]        debug_pc
`endif
);

  fetch_state_e       state;
  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic [31:0]        next_pc;
  logic [31:0]        pend_target;
  logic               pend_valid;
  logic [INSTR_W-1:0] hold_buf;
  logic               redir;
  logic               slot_done;
  logic               bubble;
  logic [INSTR_W-1:0] load_word;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req  = (state == FETCH) && !rst;

`ifdef DEBUG
  assign debug_pc = pc;
`endif

  // A stalled decode neither consumes nor records a redirect.
  assign redir     = shouldJumpOrBranch && idValid && !shouldStall;
  assign slot_done = !shouldStall && ((state == HOLD) || imem_ready);
  assign bubble    = (state == FETCH) && !imem_ready && !shouldStall;
  assign load_word = (state == HOLD) ? hold_buf : imem_rdata;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_pc = pc_plus4;
    if (redir)           next_pc = jumpOrBranchPc;
    else if (pend_valid) next_pc = pend_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      hold_buf    <= '0;
    end else begin
      if (slot_done) begin
        pc         <= next_pc;
        pend_valid <= 1'b0;
      end else if (redir) begin
        // Branch left IF/ID before its delay slot arrived: apply it later.
        pend_target <= jumpOrBranchPc;
        pend_valid  <= 1'b1;
      end

      unique case (state)
        FETCH: if (imem_ready && shouldStall) begin
          hold_buf <= imem_rdata;
          state    <= HOLD;
        end
        HOLD: if (!shouldStall) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk              (clk),
    .rst              (rst),
    .load             (slot_done),
    .bubble           (bubble),
    .next_pc_4        (pc_plus4),
    .next_instruction (load_word),
    .pc_4             (pc_4),
    .instruction      (instruction),
    .valid            (idValid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each step drives inputs after a rising edge and
// queues the expected outputs; a monitor pops and compares on the falling edge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        shouldStall;
  logic        shouldJumpOrBranch;
  logic [31:0] jumpOrBranchPc;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_4;
  logic [31:0] instruction;
  logic        idValid;
`ifdef DEBUG
  logic [31:0] debug_pc;
`endif

  if_stage dut (
    .clk                (clk),
    .rst                (rst),
    .shouldStall        (shouldStall),
    .shouldJumpOrBranch (shouldJumpOrBranch),
    .jumpOrBranchPc     (jumpOrBranchPc),
    .imem_addr          (imem_addr),
    .imem_req           (imem_req),
    .imem_rdata         (imem_rdata),
    .imem_ready         (imem_ready),
    .pc_4               (pc_4),
    .instruction        (instruction),
    .idValid            (idValid)
`ifdef DEBUG
    ,
    .debug_pc           (debug_pc)
`endif
  );

  always #5 clk = ~clk;

  // care bits: 0 addr, 1 req, 2 pc_4, 3 instruction, 4 idValid
  typedef struct {
    string       tag;
    logic [4:0]  care;
    logic [31:0] addr;
    logic        req;
    logic [31:0] pc_4;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] REQ = 5'b00010;

  localparam logic [31:0] W0   = 32'h2001_0005;
  localparam logic [31:0] W4   = 32'h1111_0004;
  localparam logic [31:0] W8   = 32'h2222_0008;
  localparam logic [31:0] BR   = 32'h1000_000E;
  localparam logic [31:0] SLOT = 32'h2002_0007;
  localparam logic [31:0] W40  = 32'h2003_0009;
  localparam logic [31:0] WTOP = 32'hDEAD_BEEF;

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s.%s: got %h expected %h", tag, field, act, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.care[0]) cmp(e.tag, "imem_addr",   imem_addr,         e.addr);
        if (e.care[1]) cmp(e.tag, "imem_req",    {31'd0, imem_req}, {31'd0, e.req});
        if (e.care[2]) cmp(e.tag, "pc_4",        pc_4,              e.pc_4);
        if (e.care[3]) cmp(e.tag, "instruction", instruction,       e.instr);
        if (e.care[4]) cmp(e.tag, "idValid",     {31'd0, idValid},  {31'd0, e.valid});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive one cycle of inputs, queue the outputs expected during that cycle.
  task automatic step(input string tag, input logic r, input logic st,
                      input logic jb, input logic [31:0] tgt,
                      input logic rdy, input logic [31:0] rd,
                      input logic [4:0] care, input logic [31:0] addr,
                      input logic req, input logic [31:0] p4,
                      input logic [31:0] ins, input logic v);
    exp_t e;
    rst = r; shouldStall = st; shouldJumpOrBranch = jb; jumpOrBranchPc = tgt;
    imem_ready = rdy; imem_rdata = rd;
    e.tag = tag; e.care = care; e.addr = addr; e.req = req;
    e.pc_4 = p4; e.instr = ins; e.valid = v;
    exp_q.push_back(e);
    tick();
  endtask

  initial begin
    rst = 1'b1; shouldStall = 1'b0; shouldJumpOrBranch = 1'b0;
    jumpOrBranchPc = '0; imem_ready = 1'b0; imem_rdata = '0;
    tick();

    //    tag          rst st jb target        rdy rdata  care addr          req pc_4          instr  v
    step("reset",      1, 0, 0, 32'h0,        0, 32'h0, ALL, 32'h0,        0, 32'h0,        32'h0, 0);
    step("fetch0",     0, 0, 0, 32'h0,        1, W0,    ALL, 32'h0,        1, 32'h0,        32'h0, 0);
    step("fetch4",     0, 0, 0, 32'h0,        1, W4,    ALL, 32'h4,        1, 32'h4,        W0,    1);
    step("stall_in",   0, 1, 0, 32'h0,        1, W8,    ALL, 32'h8,        1, 32'h8,        W4,    1);
    step("hold1",      0, 1, 0, 32'h0,        0, 32'h0, ALL, 32'h8,        0, 32'h8,        W4,    1);
    step("hold2",      0, 1, 0, 32'h0,        0, 32'h0, ALL, 32'h8,        0, 32'h8,        W4,    1);
    step("release",    0, 0, 0, 32'h0,        0, 32'h0, ALL, 32'h8,        0, 32'h8,        W4,    1);
    step("held_word",  0, 0, 0, 32'h0,        0, 32'h0, ALL, 32'hC,        1, 32'hC,        W8,    1);

    // Branch at pc_4=8 with single-cycle memory.
    step("rst_b1",     1, 0, 0, 32'h0,        0, 32'h0, REQ, 32'h0,        0, 32'h0,        32'h0, 0);
    step("b1_f0",      0, 0, 0, 32'h0,        1, W0,    ALL, 32'h0,        1, 32'h0,        32'h0, 0);
    step("b1_f4",      0, 0, 0, 32'h0,        1, BR,    ALL, 32'h4,        1, 32'h4,        W0,    1);
    step("b1_slot",    0, 0, 1, 32'h40,       1, SLOT,  ALL, 32'h8,        1, 32'h8,        BR,    1);
    step("b1_target",  0, 0, 0, 32'h0,        1, W40,   ALL, 32'h40,       1, 32'hC,        SLOT,  1);
    step("b1_after",   0, 0, 0, 32'h0,        0, 32'h0, ALL, 32'h44,       1, 32'h44,       W40,   1);

    // Same branch with slow memory: redirect is remembered across bubbles.
    step("rst_b2",     1, 0, 0, 32'h0,        0, 32'h0, REQ, 32'h0,        0, 32'h0,        32'h0, 0);
    step("b2_f0",      0, 0, 0, 32'h0,        1, W0,    REQ, 32'h0,        1, 32'h0,        32'h0, 0);
    step("b2_f4",      0, 0, 0, 32'h0,        1, BR,    5'b00001, 32'h4,   1, 32'h0,        32'h0, 0);
    step("b2_redir",   0, 0, 1, 32'h40,       0, 32'h0, ALL, 32'h8,        1, 32'h8,        BR,    1);
    step("b2_bubble",  0, 0, 1, 32'h80,       0, 32'h0, ALL, 32'h8,        1, 32'h8,        32'h0, 0);
    step("b2_slot",    0, 0, 0, 32'h0,        1, SLOT,  ALL, 32'h8,        1, 32'h8,        32'h0, 0);
    step("b2_target",  0, 0, 0, 32'h0,        0, 32'h0, ALL, 32'h40,       1, 32'hC,        SLOT,  1);

    // Reset abandons a pending redirect and an outstanding fetch.
    step("p_br",       0, 0, 0, 32'h0,        1, BR,    ALL, 32'h40,       1, 32'hC,        32'h0, 0);
    step("p_redir",    0, 0, 1, 32'h100,      0, 32'h0, ALL, 32'h44,       1, 32'h44,       BR,    1);
    step("p_rst",      1, 0, 0, 32'h0,        0, 32'h0, ALL, 32'h44,       0, 32'h44,       32'h0, 0);
    step("p_post",     0, 0, 0, 32'h0,        1, W0,    ALL, 32'h0,        1, 32'h0,        32'h0, 0);
    step("p_no_pend",  0, 0, 0, 32'h0,        0, 32'h0, ALL, 32'h4,        1, 32'h4,        W0,    1);

    // Stall and redirect together: stall wins, redirect is dropped.
    step("s_br",       0, 0, 0, 32'h0,        1, BR,    ALL, 32'h4,        1, 32'h4,        32'h0, 0);
    step("s_both",     0, 1, 1, 32'h200,      0, 32'h0, ALL, 32'h8,        1, 32'h8,        BR,    1);
    step("s_slot",     0, 0, 0, 32'h0,        1, SLOT,  ALL, 32'h8,        1, 32'h8,        BR,    1);
    step("s_seq",      0, 0, 0, 32'h0,        0, 32'h0, ALL, 32'hC,        1, 32'hC,        SLOT,  1);

    // Redirect to the top word, then wrap to zero.
    step("w_br",       0, 0, 0, 32'h0,        1, BR,    ALL, 32'hC,        1, 32'hC,        32'h0, 0);
    step("w_redir",    0, 0, 1, 32'hFFFF_FFFC, 1, SLOT, ALL, 32'h10,       1, 32'h10,       BR,    1);
    step("w_top",      0, 0, 0, 32'h0,        1, WTOP,  ALL, 32'hFFFF_FFFC, 1, 32'h14,      SLOT,  1);
    step("w_wrap",     0, 0, 0, 32'h0,        0, 32'h0, ALL, 32'h0,        1, 32'h0,        WTOP,  1);

    #10;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
